// File: rtl/frame_buffer_ctrl.sv
// Triple-buffer sequencer handing DDR frame bases to writer and reader.
// Optional macro FB_FREEZE_EN: freeze input holds the displayed buffer.
module frame_buffer_ctrl #(
    parameter logic [31:0] BUF0_ADDR = 32'h0100_0000,
    parameter logic [31:0] BUF1_ADDR = 32'h0110_0000,
    parameter logic [31:0] BUF2_ADDR = 32'h0120_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk_100Mhz,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 writer_done,
    input  logic                 reader_vsync,
    input  logic                 freeze,
    output logic [1:0]           wr_idx,
    output logic [1:0]           rd_idx,
    output logic [31:0]          wr_base_addr,
    output logic [31:0]          rd_base_addr,
    output logic                 frame_valid,
    output logic [CNT_WIDTH-1:0] drop_count,
    output logic [CNT_WIDTH-1:0] repeat_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        RUN        = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic [1:0]           r_wr_idx, w_wr_nx;
    logic [1:0]           r_rd_idx, w_rd_nx;
    logic [1:0]           r_lat_idx, w_lat_nx;
    logic                 r_new_flag, w_nf_nx;
    logic                 r_frame_valid, w_fv_nx;
    logic [CNT_WIDTH-1:0] r_drop, w_drop_nx;
    logic [CNT_WIDTH-1:0] r_rep, w_rep_nx;
    logic                 r_wd_d, r_vs_d;
    logic [31:0]          r_wr_addr, r_rd_addr;
    logic                 w_wd_ev, w_vs_ev;
    logic                 w_freeze;

`ifdef FB_FREEZE_EN
    assign w_freeze = freeze;
`else
    assign w_freeze = freeze & 1'b0;
`endif

    assign w_wd_ev = writer_done & ~r_wd_d;
    assign w_vs_ev = reader_vsync & ~r_vs_d;

    // Lowest buffer index that is neither a nor b.
    function automatic logic [1:0] f_free(
        input logic [1:0] a,
        input logic [1:0] b
    );
        if (a != 2'd0 && b != 2'd0)
            return 2'd0;
        else if (a != 2'd1 && b != 2'd1)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    // Buffer index to DDR base address.
    function automatic logic [31:0] f_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    return BUF0_ADDR;
            2'd1:    return BUF1_ADDR;
            default: return BUF2_ADDR;
        endcase
    endfunction

    // State register.
    always_ff @(posedge clk_100Mhz) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nx;
    end

    // Next-state and buffer rotation on writer/reader events.
    always_comb begin
        w_state_nx = r_state;
        w_wr_nx    = r_wr_idx;
        w_rd_nx    = r_rd_idx;
        w_lat_nx   = r_lat_idx;
        w_nf_nx    = r_new_flag;
        w_fv_nx    = r_frame_valid;
        w_drop_nx  = r_drop;
        w_rep_nx   = r_rep;
        if (!enable) begin
            w_state_nx = IDLE;
            w_wr_nx    = 2'd0;
            w_rd_nx    = 2'd2;
            w_lat_nx   = 2'd1;
            w_nf_nx    = 1'b0;
            w_fv_nx    = 1'b0;
            w_drop_nx  = '0;
            w_rep_nx   = '0;
        end else begin
            case (r_state)
                IDLE: w_state_nx = WAIT_FIRST;
                WAIT_FIRST: begin
                    if (w_wd_ev) begin
                        w_lat_nx   = r_wr_idx;
                        w_nf_nx    = 1'b1;
                        w_wr_nx    = f_free(r_rd_idx, r_wr_idx);
                        w_state_nx = RUN;
                    end
                end
                RUN: begin
                    if (w_wd_ev && r_new_flag && r_drop != '1)
                        w_drop_nx = r_drop + 1'b1;
                    if (w_wd_ev && w_vs_ev && !w_freeze) begin
                        w_lat_nx = r_wr_idx;
                        w_rd_nx  = r_wr_idx;
                        w_nf_nx  = 1'b0;
                        w_fv_nx  = 1'b1;
                        w_wr_nx  = f_free(r_wr_idx, r_wr_idx);
                    end else if (w_wd_ev) begin
                        w_lat_nx = r_wr_idx;
                        w_nf_nx  = 1'b1;
                        w_wr_nx  = f_free(r_rd_idx, r_wr_idx);
                    end else if (w_vs_ev && !w_freeze) begin
                        if (r_new_flag) begin
                            w_rd_nx = r_lat_idx;
                            w_nf_nx = 1'b0;
                            w_fv_nx = 1'b1;
                        end else if (r_rep != '1) begin
                            w_rep_nx = r_rep + 1'b1;
                        end
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // Index, flag, counter and address registers.
    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            r_wr_idx      <= 2'd0;
            r_rd_idx      <= 2'd2;
            r_lat_idx     <= 2'd1;
            r_new_flag    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_drop        <= '0;
            r_rep         <= '0;
            r_wd_d        <= 1'b0;
            r_vs_d        <= 1'b0;
            r_wr_addr     <= BUF0_ADDR;
            r_rd_addr     <= BUF2_ADDR;
        end else begin
            r_wr_idx      <= w_wr_nx;
            r_rd_idx      <= w_rd_nx;
            r_lat_idx     <= w_lat_nx;
            r_new_flag    <= w_nf_nx;
            r_frame_valid <= w_fv_nx;
            r_drop        <= w_drop_nx;
            r_rep         <= w_rep_nx;
            r_wd_d        <= enable & writer_done;
            r_vs_d        <= enable & reader_vsync;
            r_wr_addr     <= f_addr(w_wr_nx);
            r_rd_addr     <= f_addr(w_rd_nx);
        end
    end

    assign wr_idx       = r_wr_idx;
    assign rd_idx       = r_rd_idx;
    assign wr_base_addr = r_wr_addr;
    assign rd_base_addr = r_rd_addr;
    assign frame_valid  = r_frame_valid;
    assign drop_count   = r_drop;
    assign repeat_count = r_rep;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Bench for frame_buffer_ctrl: directed plan plus random traffic
// against a frame-level reference model.
module tb_frame_buffer_ctrl;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          writer_done;
    logic          reader_vsync;
    logic          freeze;
    logic [1:0]    wr_idx;
    logic [1:0]    rd_idx;
    logic [31:0]   wr_base_addr;
    logic [31:0]   rd_base_addr;
    logic          frame_valid;
    logic [CW-1:0] drop_count;
    logic [CW-1:0] repeat_count;

    int n_chk = 0;
    int n_err = 0;

    // Model state: phase 0 idle, 1 waiting first frame, 2 running.
    int m_ph;
    int m_wr, m_rd, m_lat;
    bit m_nf, m_fv;
    int m_drop, m_rep;
    bit p_wd, p_vs;

    always #5 clk = ~clk;

    frame_buffer_ctrl #(
        .CNT_WIDTH(CW)
    ) dut (
        .clk_100Mhz  (clk),
        .rst         (rst),
        .enable      (enable),
        .writer_done (writer_done),
        .reader_vsync(reader_vsync),
        .freeze      (freeze),
        .wr_idx      (wr_idx),
        .rd_idx      (rd_idx),
        .wr_base_addr(wr_base_addr),
        .rd_base_addr(rd_base_addr),
        .frame_valid (frame_valid),
        .drop_count  (drop_count),
        .repeat_count(repeat_count)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int addr_of(input int i);
        int a;
        a = 32'h0100_0000 + i * 32'h0010_0000;
        return a;
    endfunction

    // Any buffer outside the excluded set; lowest wins.
    function automatic int spare(input int a, input int b);
        for (int i = 0; i < 3; i++)
            if (i != a && i != b) return i;
        return 0;
    endfunction

    task automatic m_clear();
        m_ph = 0;
        m_wr = 0;
        m_rd = 2;
        m_lat = 1;
        m_nf = 0;
        m_fv = 0;
        m_drop = 0;
        m_rep = 0;
        p_wd = 0;
        p_vs = 0;
    endtask

    task automatic m_update();
        bit wd, vs, fz;
        if (rst || !enable) begin
            m_clear();
            return;
        end
        wd = writer_done && !p_wd;
        vs = reader_vsync && !p_vs;
        p_wd = writer_done;
        p_vs = reader_vsync;
`ifdef FB_FREEZE_EN
        fz = freeze;
`else
        fz = 0;
`endif
        if (fz) vs = 0;
        if (m_ph == 0) begin
            m_ph = 1;
        end else if (m_ph == 1) begin
            if (wd) begin
                m_lat = m_wr;
                m_nf = 1;
                m_wr = spare(m_rd, m_lat);
                m_ph = 2;
            end
        end else begin
            if (wd) begin
                if (m_nf) m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
                m_lat = m_wr;
                m_nf = 1;
            end
            if (vs) begin
                if (m_nf) begin
                    m_rd = m_lat;
                    m_nf = 0;
                    m_fv = 1;
                end else begin
                    m_rep = (m_rep < CMAX) ? m_rep + 1 : CMAX;
                end
            end
            if (wd) m_wr = spare(m_rd, m_lat);
        end
    endtask

    task automatic compare_all();
        chk("wr_idx", wr_idx, m_wr);
        chk("rd_idx", rd_idx, m_rd);
        chk("wr_base", wr_base_addr, addr_of(m_wr));
        chk("rd_base", rd_base_addr, addr_of(m_rd));
        chk("frame_valid", frame_valid, m_fv);
        chk("drop", drop_count, m_drop);
        chk("repeat", repeat_count, m_rep);
        if (m_ph != 0)
            chk("wr_ne_rd", wr_idx != rd_idx, 1);
    endtask

    task automatic step();
        @(posedge clk);
        m_update();
        #1;
        compare_all();
    endtask

    task automatic pulse(input bit wd, input bit vs);
        writer_done = wd;
        reader_vsync = vs;
        step();
        writer_done = 0;
        reader_vsync = 0;
        step();
    endtask

    initial begin
        int rd_hold;
        rst = 1;
        enable = 0;
        writer_done = 0;
        reader_vsync = 0;
        freeze = 0;
        m_clear();
        step();
        step();
        chk("rst_wr", wr_idx, 0);
        chk("rst_rd", rd_idx, 2);
        chk("rst_rdaddr", rd_base_addr, 32'h0120_0000);
        rst = 0;
        enable = 1;
        step();
        step();
        chk("idle_wraddr", wr_base_addr, 32'h0100_0000);
        pulse(0, 1);
        chk("wf_repeat", repeat_count, 0);
        chk("wf_rd", rd_idx, 2);
        pulse(1, 0);
        chk("first_wr", wr_idx, 1);
        pulse(0, 1);
        chk("first_rd", rd_idx, 0);
        chk("first_rdaddr", rd_base_addr, 32'h0100_0000);
        chk("first_fv", frame_valid, 1);
        pulse(1, 0);
        chk("second_wr", wr_idx, 2);
        pulse(0, 1);
        chk("second_rd", rd_idx, 1);
        repeat (3) pulse(1, 0);
        chk("drop2", drop_count, 2);
        pulse(0, 1);
        pulse(0, 1);
        pulse(0, 1);
        chk("repeat2", repeat_count, 2);
        pulse(1, 0);
        pulse(0, 1);
        chk("pre_both_wr", wr_idx, 1);
        chk("pre_both_rd", rd_idx, 0);
        pulse(1, 1);
        chk("both_rd", rd_idx, 1);
        chk("both_wr", wr_idx, 0);
        chk("both_drop", drop_count, 2);
        pulse(0, 1);
        chk("both_nf_clear", repeat_count, 3);
        writer_done = 1;
        repeat (10) step();
        writer_done = 0;
        step();
        chk("held_drop", drop_count, 2);
        repeat (20) pulse(1, 0);
        chk("drop_sat", drop_count, CMAX);
        pulse(0, 1);
        repeat (20) pulse(0, 1);
        chk("rep_sat", repeat_count, CMAX);
        writer_done = 1;
        reader_vsync = 1;
        rst = 1;
        step();
        rst = 0;
        writer_done = 0;
        reader_vsync = 0;
        chk("midrst_drop", drop_count, 0);
        chk("midrst_fv", frame_valid, 0);
        step();
        step();
        pulse(1, 0);
        pulse(0, 1);
        pulse(1, 0);
        rd_hold = rd_idx;
        freeze = 1;
        repeat (4) pulse(0, 1);
`ifdef FB_FREEZE_EN
        chk("frz_rd", rd_idx, rd_hold);
        chk("frz_rep", repeat_count, 0);
`endif
        freeze = 0;
        pulse(0, 1);
        enable = 0;
        step();
        chk("dis_wr", wr_idx, 0);
        enable = 1;
        for (int i = 0; i < 4000; i++) begin
            writer_done = ($urandom_range(0, 3) == 0);
            reader_vsync = ($urandom_range(0, 3) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            enable = ($urandom_range(0, 99) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
- Triple-buffer sequencer between the AXI4 stream-to-DDR frame writer and the HDMI-side DDR frame reader.
- Tracks three frame buffers in DDR: one being written, one being displayed, and one holding the latest completed frame.
- Hands each side a base address, so the writer never overwrites the frame on screen and the reader always takes the newest complete frame.
- Counts dropped and repeated frames for debug.

Parameters:
BUF0_ADDR, 32'h0100_0000, DDR base address of buffer 0
BUF1_ADDR, 32'h0110_0000, DDR base address of buffer 1
BUF2_ADDR, 32'h0120_0000, DDR base address of buffer 2
CNT_WIDTH, 16, width of drop/repeat counters

Ports:
clk_100Mhz  in  1  system/AXI clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  controller run enable
writer_done  in  1  writer finished a full frame (rising-edge detected internally)
reader_vsync  in  1  reader starting a new frame fetch (rising-edge detected internally)
freeze  in  1  hold display buffer (used only with FB_FREEZE_EN)
wr_idx  out  2  buffer index the writer targets
rd_idx  out  2  buffer index the reader targets
wr_base_addr  out  32  BUFn_ADDR selected by wr_idx
rd_base_addr  out  32  BUFn_ADDR selected by rd_idx
frame_valid  out  1  rd_idx holds a completed frame
drop_count  out  CNT_WIDTH  completed frames overwritten before being read
repeat_count  out  CNT_WIDTH  reader starts with no new frame available

Behaviour:
- Reset and IDLE values:
  - wr_idx=0, rd_idx=2, internal lat_idx=1, new_flag=0.
  - frame_valid=0, drop_count=0, repeat_count=0.
  - Edge-detect registers cleared; state=IDLE.
- Address outputs: registered decode of the indices, updated in the same edge as the indices. Index 3 never occurs.
- Events:
  - Edge detect: wd_ev = writer_done & ~writer_done_d; vs_ev = reader_vsync & ~reader_vsync_d.
  - An event is sampled on edge N (first cycle the input is high). Indices and flags change on that same edge.
  - New values are visible in the cycle after the input first went high.
- States:
  - IDLE: all state held at reset values. enable=1 -> WAIT_FIRST.
  - WAIT_FIRST: no completed frame exists yet.
    - vs_ev: ignored; repeat_count unchanged.
    - wd_ev: lat_idx<=wr_idx; new_flag<=1; wr_idx<=lowest index not equal to rd_idx or the new lat_idx; -> RUN.
  - RUN, wd_ev only:
    - If new_flag was already 1, drop_count++ (saturating).
    - lat_idx<=wr_idx; new_flag<=1; wr_idx<=lowest index not equal to rd_idx or the new lat_idx.
  - RUN, vs_ev only:
    - If new_flag=1: rd_idx<=lat_idx, new_flag<=0, frame_valid<=1.
    - Else: repeat_count++ (saturating); rd_idx unchanged.
  - RUN, wd_ev and vs_ev in the same cycle: the write completes first, then the read.
    - lat_idx<=wr_idx; rd_idx<=wr_idx; new_flag<=0; frame_valid<=1.
    - wr_idx<=lowest index not equal to the new rd_idx.
    - drop_count++ if new_flag was 1 before the event; repeat_count unchanged.
  - enable=0 in any state -> IDLE next edge. All indices, flags and counters return to reset values.
- Invariants, checked every cycle outside IDLE:
  - wr_idx != rd_idx.
  - In RUN with new_flag=1, wr_idx != lat_idx.
- Counters saturate at all-ones and never wrap.
- Reset mid-frame takes priority over any same-cycle event. All outputs take reset values on the next edge.
- Level-held writer_done or reader_vsync produces exactly one event.

Optional Feature:
- Macro: FB_FREEZE_EN.
- Defined:
  - freeze=1 in RUN blocks rd_idx updates on vs_ev.
  - new_flag is left unchanged by vs_ev; repeat_count is not incremented.
  - Writer keeps cycling between the two non-displayed buffers; each wd_ev while new_flag=1 increments drop_count.
  - Releasing freeze: the next vs_ev takes lat_idx.
- Undefined: freeze port exists but is ignored; behaviour as in Behaviour.

Test Plan:
- Reset then enable=1 -> wr_idx=0, rd_idx=2, wr_base_addr=32'h0100_0000, rd_base_addr=32'h0120_0000, frame_valid=0. vs_ev in WAIT_FIRST -> no change, repeat_count=0.
- wd_ev -> wr_idx=1, lat=0, RUN. Then vs_ev -> rd_idx=0, rd_base_addr=32'h0100_0000, frame_valid=1. Then wd_ev -> wr_idx=2. Then vs_ev -> rd_idx=1.
- Three wd_ev with no vs_ev after the first frame is read -> drop_count=2. wr_idx never equals rd_idx.
- Two vs_ev with no wd_ev after a frame is read -> repeat_count=2; rd_idx unchanged.
- wd_ev and vs_ev in the same cycle with wr_idx=1, rd_idx=0 -> rd_idx=1, wr_idx=0, new_flag=0.
- writer_done held high 10 cycles -> single event. rst pulsed mid-RUN -> all outputs at reset values next cycle. With FB_FREEZE_EN and freeze=1: four vs_ev -> rd_idx constant, repeat_count=0.
